// File: rtl/led_sequencer.sv
// LED bank sequencer: prescaled pattern stepping with a 4-phase req/ack mode-change handshake.
// Optional brightness gating is compiled in with `define LED_PWM_EN (adds the BRIGHT port).
module led_sequencer #(
  parameter int CLK_HZ  = 12000000,
  parameter int STEP_HZ = 8,
  parameter int N_LEDS  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MODE_REQ,
  input  logic [1:0]        MODE_SEL,
  output logic              MODE_ACK,
  input  logic              PAUSE,
  output logic [1:0]        MODE,
  output logic              STEP,
`ifdef LED_PWM_EN
  input  logic [2:0]        BRIGHT,
`endif
  output logic [N_LEDS-1:0] LED
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_BLINK = 2'd1;
  localparam logic [1:0] M_SCAN  = 2'd2;
  localparam logic [1:0] M_COUNT = 2'd3;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("led_sequencer: CLK_HZ/STEP_HZ must be >= 2");
    end
    if (N_LEDS < 2) begin : g_bad_width
      $error("led_sequencer: N_LEDS must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACK  = 2'd2
  } hs_state_t;

  hs_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        mode_q, mode_d;
  logic [N_LEDS-1:0] pat_q, pat_d;
  logic              dir_up_q, dir_up_d;
  logic              ack_q, ack_d;
  logic              step_q, step_d;
  logic              tick;
  logic              load;

  // Prescaler: holds while paused, so a paused sequencer never ticks.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (!PAUSE) begin
      if (cnt_q == CW'(DIV - 1)) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ack_d    = ack_q;
    mode_d   = mode_q;
    pat_d    = pat_q;
    dir_up_d = dir_up_q;
    step_d   = tick;
    load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MODE_REQ) begin
          pend_d  = MODE_SEL;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (tick) begin
          load    = 1'b1;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!MODE_REQ) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // A loading tick installs the new pattern instead of advancing the old one.
    if (load) begin
      mode_d   = pend_q;
      dir_up_d = 1'b1;
      case (pend_q)
        M_BLINK: pat_d = '1;
        M_SCAN:  pat_d = N_LEDS'(1);
        default: pat_d = '0;
      endcase
    end else if (tick) begin
      case (mode_q)
        M_OFF:   pat_d = '0;
        M_BLINK: pat_d = (pat_q == '0) ? '1 : '0;
        M_SCAN: begin
          if (dir_up_q) begin
            if (pat_q[N_LEDS-1]) begin
              pat_d    = pat_q >> 1;
              dir_up_d = 1'b0;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              pat_d    = pat_q << 1;
              dir_up_d = 1'b1;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        M_COUNT: pat_d = pat_q + 1'b1;
        default: pat_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= M_OFF;
      ack_q    <= 1'b0;
      mode_q   <= M_BLINK;
      pat_q    <= '0;
      dir_up_q <= 1'b1;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      dir_up_q <= dir_up_d;
      step_q   <= step_d;
    end
  end

  assign MODE_ACK = ack_q;
  assign MODE     = mode_q;
  assign STEP     = step_q;

`ifdef LED_PWM_EN
  logic [2:0]        pwm_q, pwm_d;
  logic [N_LEDS-1:0] led_q, led_d;

  // Duty is (BRIGHT+1)/8; the gate is registered so LED lags the pattern by one cycle.
  always_comb begin
    pwm_d = pwm_q + 3'd1;
    led_d = pat_q & {N_LEDS{pwm_q <= BRIGHT}};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_q <= '0;
      led_q <= '0;
    end else begin
      pwm_q <= pwm_d;
      led_q <= led_d;
    end
  end

  assign LED = led_q;
`else
  assign LED = pat_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Directed, table-driven bench for led_sequencer at DIV=8 (CLK_HZ=80, STEP_HZ=10).
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_req;
  logic [1:0] mode_sel;
  logic       mode_ack;
  logic       pause;
  logic [1:0] mode;
  logic       step;
  logic [7:0] led;
  logic [2:0] bright;

  int n_cmp = 0;
  int n_bad = 0;

  led_sequencer #(.CLK_HZ(80), .STEP_HZ(10), .N_LEDS(8)) dut (
    .CLK      (clk),
    .RST      (rst),
    .MODE_REQ (mode_req),
    .MODE_SEL (mode_sel),
    .MODE_ACK (mode_ack),
    .PAUSE    (pause),
    .MODE     (mode),
    .STEP     (step),
`ifdef LED_PWM_EN
    .BRIGHT   (bright),
`endif
    .LED      (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    int         n;
    logic       rq;
    logic [1:0] sel;
    logic       pz;
    logic [7:0] led;
    logic [1:0] mode;
    logic       ack;
    logic       step;
  } vec_t;

  vec_t tbl[23];

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_led(input string nm, input logic [7:0] el);
    n_cmp++;
    if (led !== el) begin
      n_bad++;
      $display("FAIL %s: LED=%02h expected %02h", nm, led, el);
    end
  endtask

  // With the PWM gate the LED lags the pattern by a cycle, so its check is deferred.
  task automatic chk(input string nm, input logic [7:0] el, input logic [1:0] em,
                     input logic ea, input logic es);
    n_cmp++;
    if (mode !== em || mode_ack !== ea || step !== es) begin
      n_bad++;
      $display("FAIL %s: MODE=%0d ACK=%b STEP=%b expected MODE=%0d ACK=%b STEP=%b",
               nm, mode, mode_ack, step, em, ea, es);
    end
`ifdef LED_PWM_EN
    fork
      begin
        automatic string      n2 = nm;
        automatic logic [7:0] e2 = el;
        #10;
        chk_led(n2, e2);
      end
    join_none
`else
    chk_led(nm, el);
`endif
  endtask

  initial begin
    int hi;
    tbl[0]  = '{"blink_pre",     7, 1'b0, 2'd0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0};
    tbl[1]  = '{"blink_on",      1, 1'b0, 2'd0, 1'b0, 8'hFF, 2'd1, 1'b0, 1'b1};
    tbl[2]  = '{"step_width",    1, 1'b0, 2'd0, 1'b0, 8'hFF, 2'd1, 1'b0, 1'b0};
    tbl[3]  = '{"blink_off",     7, 1'b0, 2'd0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b1};
    tbl[4]  = '{"blink_on2",     8, 1'b0, 2'd0, 1'b0, 8'hFF, 2'd1, 1'b0, 1'b1};
    tbl[5]  = '{"blink_off2",    8, 1'b0, 2'd0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b1};
    tbl[6]  = '{"blink_on3",     8, 1'b0, 2'd0, 1'b0, 8'hFF, 2'd1, 1'b0, 1'b1};
    tbl[7]  = '{"scan_accept",   1, 1'b1, 2'd2, 1'b0, 8'hFF, 2'd1, 1'b0, 1'b0};
    tbl[8]  = '{"scan_sel_chg",  6, 1'b1, 2'd3, 1'b0, 8'hFF, 2'd1, 1'b0, 1'b0};
    tbl[9]  = '{"scan_load",     1, 1'b1, 2'd3, 1'b0, 8'h01, 2'd2, 1'b1, 1'b1};
    tbl[10] = '{"scan_ack_hold", 8, 1'b1, 2'd3, 1'b0, 8'h02, 2'd2, 1'b1, 1'b1};
    tbl[11] = '{"scan_ack_fall", 1, 1'b0, 2'd0, 1'b0, 8'h02, 2'd2, 1'b0, 1'b0};
    tbl[12] = '{"scan_04",       7, 1'b0, 2'd0, 1'b0, 8'h04, 2'd2, 1'b0, 1'b1};
    tbl[13] = '{"scan_40",      32, 1'b0, 2'd0, 1'b0, 8'h40, 2'd2, 1'b0, 1'b1};
    tbl[14] = '{"scan_80",       8, 1'b0, 2'd0, 1'b0, 8'h80, 2'd2, 1'b0, 1'b1};
    tbl[15] = '{"scan_40_down",  8, 1'b0, 2'd0, 1'b0, 8'h40, 2'd2, 1'b0, 1'b1};
    tbl[16] = '{"scan_01",      48, 1'b0, 2'd0, 1'b0, 8'h01, 2'd2, 1'b0, 1'b1};
    tbl[17] = '{"scan_02_up",    8, 1'b0, 2'd0, 1'b0, 8'h02, 2'd2, 1'b0, 1'b1};
    tbl[18] = '{"pre_pause",     3, 1'b0, 2'd0, 1'b0, 8'h02, 2'd2, 1'b0, 1'b0};
    tbl[19] = '{"paused",       30, 1'b1, 2'd0, 1'b1, 8'h02, 2'd2, 1'b0, 1'b0};
    tbl[20] = '{"unpause_wait",  4, 1'b1, 2'd0, 1'b0, 8'h02, 2'd2, 1'b0, 1'b0};
    tbl[21] = '{"off_load",      1, 1'b1, 2'd0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1};
    tbl[22] = '{"off_ack_fall",  1, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};

    rst = 1'b1; mode_req = 1'b0; mode_sel = 2'd0; pause = 1'b0; bright = 3'd7;
    run(1);
    chk("reset", 8'h00, 2'd1, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      mode_req = tbl[i].rq;
      mode_sel = tbl[i].sel;
      pause    = tbl[i].pz;
      run(tbl[i].n);
      chk(tbl[i].nm, tbl[i].led, tbl[i].mode, tbl[i].ack, tbl[i].step);
      $display("vec %0d %s: LED=%02h MODE=%0d ACK=%b STEP=%b", i, tbl[i].nm, led, mode, mode_ack, step);
    end

    // COUNT: load, then every value 01..FF and the wrap to 00 one step apart.
    mode_req = 1'b1; mode_sel = 2'd3;
    run(1);
    run(5);
    chk("count_wait", 8'h00, 2'd0, 1'b0, 1'b0);
    run(1);
    chk("count_load", 8'h00, 2'd3, 1'b1, 1'b1);
    mode_req = 1'b0;
    run(1);
    chk("count_ack_fall", 8'h00, 2'd3, 1'b0, 1'b0);
    run(7);
    chk("count_1", 8'h01, 2'd3, 1'b0, 1'b1);
    for (int s = 2; s <= 256; s++) begin
      automatic logic [8:0] v = 9'(s);
      run(8);
      chk("count_step", v[7:0], 2'd3, 1'b0, 1'b1);
    end
    $display("count sweep done: LED=%02h", led);

    // Reset while a COUNT request is pending, then re-acceptance of the held request.
    mode_req = 1'b1; mode_sel = 2'd3;
    run(2);
    chk("rst_pend", 8'h00, 2'd3, 1'b0, 1'b0);
    rst = 1'b1;
    run(1);
    chk("rst_abort", 8'h00, 2'd1, 1'b0, 1'b0);
    rst = 1'b0;
    run(7);
    chk("rst_reaccept_wait", 8'h00, 2'd1, 1'b0, 1'b0);
    run(1);
    chk("rst_reaccept_load", 8'h00, 2'd3, 1'b1, 1'b1);
    $display("reset abort sequence: MODE=%0d ACK=%b", mode, mode_ack);

    // Re-selecting the active mode restarts its pattern.
    mode_req = 1'b0;
    run(1);
    chk("same_ack_fall", 8'h00, 2'd3, 1'b0, 1'b0);
    run(7);
    chk("same_cnt1", 8'h01, 2'd3, 1'b0, 1'b1);
    run(8);
    chk("same_cnt2", 8'h02, 2'd3, 1'b0, 1'b1);
    mode_req = 1'b1; mode_sel = 2'd3;
    run(8);
    chk("reload_same", 8'h00, 2'd3, 1'b1, 1'b1);
    mode_req = 1'b0;
    run(1);
    chk("reload_ack_fall", 8'h00, 2'd3, 1'b0, 1'b0);

`ifdef LED_PWM_EN
    mode_req = 1'b1; mode_sel = 2'd1;
    run(7);
    chk("pwm_blink_load", 8'hFF, 2'd1, 1'b1, 1'b1);
    run(1);
    pause = 1'b1; mode_req = 1'b0; bright = 3'd2;
    run(2);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      run(1);
      if (led === 8'hFF) hi++;
    end
    n_cmp++;
    if (hi != 3) begin
      n_bad++;
      $display("FAIL pwm_bright2: high cycles=%0d expected 3", hi);
    end
    $display("pwm bright=2: high %0d of 8", hi);
    bright = 3'd7;
    run(1);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      run(1);
      if (led === 8'hFF) hi++;
    end
    n_cmp++;
    if (hi != 8) begin
      n_bad++;
      $display("FAIL pwm_bright7: high cycles=%0d expected 8", hi);
    end
    $display("pwm bright=7: high %0d of 8", hi);
    pause = 1'b0;
`endif

    run(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Controller that owns the LED bank and sequences it through selectable display patterns.
- Paced by an internal prescaler off the 12 MHz board clock.
- Mode changes arrive from a requester (button debouncer, UART command decoder, etc.) over a 4-phase req/ack handshake.
- Changes are applied only on step boundaries, so patterns never glitch mid-step.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz.
- STEP_HZ, 8, pattern step rate in Hz. DIV = CLK_HZ/STEP_HZ must be >= 2; elaboration error otherwise.
- N_LEDS, 8, LED bank width, >= 2.

Ports:
- CLK  in  1  system clock (12 MHz).
- RST  in  1  synchronous reset, active-high.
- MODE_REQ  in  1  mode-change request (level, 4-phase).
- MODE_SEL  in  2  requested mode; sampled when MODE_REQ is accepted.
- MODE_ACK  out  1  request completed; held high until MODE_REQ falls.
- PAUSE  in  1  freezes prescaler and pattern while high.
- MODE  out  2  currently active mode.
- STEP  out  1  one-cycle pulse on each pattern step.
- LED  out  N_LEDS  LED drive, active-high.

Behaviour:
- Clocking and reset: one clock domain (CLK). Reset is synchronous and active-high (RST).
- Reset values: MODE=1 (BLINK), LED=0, MODE_ACK=0, STEP=0, prescaler=0, scan direction=up, handshake FSM=IDLE.
- Prescaler:
  - Counter width clog2(DIV), counts 0..DIV-1.
  - tick is asserted in the cycle where the counter equals DIV-1 and PAUSE=0; the counter wraps to 0 on that cycle.
  - PAUSE=1 holds the counter value. No ticks while paused.
- STEP: registered copy of tick (one cycle after tick). Same cycle that LED/MODE show the updated value.
- Modes. On each tick not consumed by a mode load:
  - 0 OFF: LED=0.
  - 1 BLINK: LED toggles between all-ones and all-zeros.
  - 2 SCAN: one-hot bounce. For N_LEDS=8 the sequence is 01,02,04,...,80,40,...,01,02. Direction flips on reaching bit N_LEDS-1 or bit 0. Each end position is shown for exactly one step.
  - 3 COUNT: binary up-count, wraps all-ones -> 0.
- Handshake FSM:
  - IDLE: MODE_REQ=1 -> latch MODE_SEL into pend, go to PEND.
  - PEND: on tick -> MODE<=pend, LED<=initial pattern, scan dir<=up, MODE_ACK<=1, go to ACK. That tick does not also advance the pattern.
  - ACK: MODE_ACK stays 1 while MODE_REQ=1. When MODE_REQ=0 -> MODE_ACK<=0, go to IDLE.
  - Initial patterns on load: OFF 0, BLINK all-ones, SCAN bit0, COUNT 0.
- Boundary rules:
  - MODE_SEL changing after acceptance is ignored.
  - Selecting the already-active mode still reloads its initial pattern and acks.
  - Requests stay deferred while PAUSE=1, so ack latency is unbounded.
  - Request latency when not paused: 1 to DIV+1 cycles from acceptance to MODE_ACK rising.
  - A new request needs MODE_REQ low for at least one cycle (through the ACK->IDLE return).
  - RST at any point aborts a pending change and returns all outputs to reset values on the next edge.
  - RST has priority over tick and over MODE_REQ.

Optional Feature:
- Macro: LED_PWM_EN.
- When defined:
  - Extra port BRIGHT (in, 3 bits).
  - Free-running 3-bit PWM counter p, incrementing every CLK and cleared by RST.
  - LED = pattern AND replicate(p <= BRIGHT). BRIGHT=7 gives full on; BRIGHT=0 gives 1/8 duty.
  - The gate is registered, adding 1 cycle of latency to LED only. STEP and MODE timing are unchanged.
- When undefined: no BRIGHT port and no PWM logic. LED = pattern register directly.

Test Plan (bench uses CLK_HZ=80, STEP_HZ=10, so DIV=8):
- Reset then run 40 cycles -> MODE=1; LED sequence 00,FF,00,FF,00 with transitions every 8 cycles; STEP is a 1-cycle pulse coincident with each change.
- Request MODE_SEL=2, then run 20 steps -> MODE_ACK rises within 9 cycles; LED=01 at load, then 02,04,08,10,20,40,80,40,20,...; ACK falls 1 cycle after MODE_REQ drops.
- COUNT mode for 257 steps -> LED goes 00..FF, then 00; no skipped values.
- PAUSE high for 30 cycles mid-SCAN, with a MODE_SEL=0 request issued while paused -> LED, MODE and prescaler frozen, MODE_ACK stays 0; after PAUSE falls, the ack and LED=00 land on the next tick.
- RST asserted while FSM=PEND (MODE_SEL=3) -> next edge gives MODE=1, LED=00, MODE_ACK=0; the held MODE_REQ is re-accepted after RST falls.
- With LED_PWM_EN defined, BLINK, LED pattern FF, BRIGHT=2 -> each LED high 3 of every 8 cycles; BRIGHT=7 -> constantly high.
